// File: rtl/snn_win_pkg.sv
// Shared constants and types for the 5x5 receptive-field window generator.
package snn_win_pkg;

  localparam int WIN_SZ    = 5;
  localparam int WIN_TAPS  = WIN_SZ * WIN_SZ;
  localparam int PIX_W_DEF = 8;

  typedef enum logic {IDLE, ACTIVE} state_t;

endpackage

// File: rtl/line_buffer_row.sv
// One-row delay line: dout is the sample written IMG_W enabled cycles earlier.
module line_buffer_row #(
  parameter int unsigned IMG_W = 28,
  parameter int unsigned PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);

  localparam int unsigned AW = $clog2(IMG_W);

  logic [PIX_W-1:0] mem [IMG_W];
  logic [AW-1:0]    ptr;

  // Read-before-write: the slot about to be overwritten holds the oldest sample.
  assign dout = mem[ptr];

  // Circular pointer advances only on enabled samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == AW'(IMG_W - 1)) ? '0 : ptr + 1'b1;
    end
  end

  // Storage has no reset; stale contents are masked by the window position logic.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr] <= din;
    end
  end

endmodule

// File: rtl/window_gen5x5.sv
// Raster pixel stream to 5x5 sliding window taps, fully-inside windows only.
module window_gen5x5
  import snn_win_pkg::*;
#(
  parameter int unsigned IMG_W = 28,
  parameter int unsigned IMG_H = 28,
  parameter int unsigned PIX_W = PIX_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PIX_W-1:0]         pix_in,
  input  logic                     pix_valid,
  input  logic                     sof,
  output logic [PIX_W-1:0]         val1,  val2,  val3,  val4,  val5,
  output logic [PIX_W-1:0]         val6,  val7,  val8,  val9,  val10,
  output logic [PIX_W-1:0]         val11, val12, val13, val14, val15,
  output logic [PIX_W-1:0]         val16, val17, val18, val19, val20,
  output logic [PIX_W-1:0]         val21, val22, val23, val24, val25,
  output logic                     win_valid,
  output logic [$clog2(IMG_H)-1:0] win_row,
  output logic [$clog2(IMG_W)-1:0] win_col,
  output logic                     frame_done,
  output logic                     frame_err
);

  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned CW = $clog2(IMG_W);

  state_t           state_q;
  logic [RW-1:0]    row_q, cur_r;
  logic [CW-1:0]    col_q, cur_c;
  logic             accept, last_col, last_row, in_win;
  logic [PIX_W-1:0] lb_in  [WIN_SZ-1];
  logic [PIX_W-1:0] lb_out [WIN_SZ-1];
  logic [PIX_W-1:0] col_in [WIN_SZ];
  logic [PIX_W-1:0] win_q  [WIN_SZ][WIN_SZ];

  // sof forces the accepted pixel to (0,0) regardless of state.
  assign accept   = pix_valid && (sof || (state_q == ACTIVE));
  assign cur_r    = sof ? '0 : row_q;
  assign cur_c    = sof ? '0 : col_q;
  assign last_col = (cur_c == CW'(IMG_W - 1));
  assign last_row = (cur_r == RW'(IMG_H - 1));
  assign in_win   = (cur_r >= RW'(WIN_SZ - 1)) && (cur_c >= CW'(WIN_SZ - 1));

  // Line buffer chain: stage i outputs the pixel i+1 rows above the current one.
  assign lb_in[0] = pix_in;
  for (genvar i = 0; i < WIN_SZ - 1; i++) begin : g_lb
    if (i > 0) begin : g_chain
      assign lb_in[i] = lb_out[i-1];
    end
    line_buffer_row #(
      .IMG_W(IMG_W),
      .PIX_W(PIX_W)
    ) u_lb (
      .clk (clk),
      .rst (rst),
      .en  (accept),
      .din (lb_in[i]),
      .dout(lb_out[i])
    );
    // Oldest row (k=0) comes from the deepest buffer.
    assign col_in[WIN_SZ-2-i] = lb_out[i];
  end
  assign col_in[WIN_SZ-1] = pix_in;

  // FSM, raster counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      win_valid  <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (accept) begin
        frame_err  <= sof && (state_q == ACTIVE) && ((row_q != '0) || (col_q != '0));
        frame_done <= last_col && last_row;
        if (last_col) begin
          col_q <= '0;
          if (last_row) begin
            row_q   <= '0;
            state_q <= IDLE;
          end else begin
            row_q   <= cur_r + 1'b1;
            state_q <= ACTIVE;
          end
        end else begin
          col_q   <= cur_c + 1'b1;
          row_q   <= cur_r;
          state_q <= ACTIVE;
        end
        if (in_win) begin
          win_valid <= 1'b1;
          win_row   <= cur_r - RW'(2);
          win_col   <= cur_c - CW'(2);
        end
      end
    end
  end

  // 5x5 window shifts left by one column per accepted pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < WIN_SZ; k++) begin
        for (int j = 0; j < WIN_SZ; j++) begin
          win_q[k][j] <= '0;
        end
      end
    end else if (accept) begin
      for (int k = 0; k < WIN_SZ; k++) begin
        for (int j = 0; j < WIN_SZ - 1; j++) begin
          win_q[k][j] <= win_q[k][j+1];
        end
        win_q[k][WIN_SZ-1] <= col_in[k];
      end
    end
  end

  assign val1  = win_q[0][0];
  assign val2  = win_q[0][1];
  assign val3  = win_q[0][2];
  assign val4  = win_q[0][3];
  assign val5  = win_q[0][4];
  assign val6  = win_q[1][0];
  assign val7  = win_q[1][1];
  assign val8  = win_q[1][2];
  assign val9  = win_q[1][3];
  assign val10 = win_q[1][4];
  assign val11 = win_q[2][0];
  assign val12 = win_q[2][1];
  assign val13 = win_q[2][2];
  assign val14 = win_q[2][3];
  assign val15 = win_q[2][4];
  assign val16 = win_q[3][0];
  assign val17 = win_q[3][1];
  assign val18 = win_q[3][2];
  assign val19 = win_q[3][3];
  assign val20 = win_q[3][4];
  assign val21 = win_q[4][0];
  assign val22 = win_q[4][1];
  assign val23 = win_q[4][2];
  assign val24 = win_q[4][3];
  assign val25 = win_q[4][4];

endmodule
